// File: rtl/maquina_cafe_if.sv
// Front-panel / valve-driver bundle for the coffee-machine controller.
// master: the panel side that drives requests and watches valves/credit.
// slave:  the controller itself.
interface maquina_cafe_if #(
    parameter int N_BEBIDAS = 5,
    parameter int CREDIT_W  = 12
);
    logic [N_BEBIDAS-1:0] sel;
    logic                 azucar_req;
    logic                 coin_c;
    logic                 coin_q;
    logic                 cancel;
    logic                 agua;
    logic                 cafe;
    logic                 leche;
    logic                 choco;
    logic                 azucar;
    logic                 bebida_lista;
    logic                 cambio_valid;
    logic [CREDIT_W-1:0]  cambio;
    logic [CREDIT_W-1:0]  credito;
    logic                 busy;
    logic                 err;

    modport master (
        output sel, azucar_req, coin_c, coin_q, cancel,
        input  agua, cafe, leche, choco, azucar,
        input  bebida_lista, cambio_valid, cambio, credito, busy, err
    );

    modport slave (
        input  sel, azucar_req, coin_c, coin_q, cancel,
        output agua, cafe, leche, choco, azucar,
        output bebida_lista, cambio_valid, cambio, credito, busy, err
    );
endinterface

// File: rtl/maquina_cafe_param.sv
// Coffee-machine controller: coin credit, drink selection against a price
// table, timed ingredient valves from a per-drink recipe, then change return.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// S_IDLE   | waiting for coins, cancel or a drink selection
// S_AGUA   | water valve open for STEP_CYCLES cycles
// S_CAFE   | coffee valve open
// S_LECHE  | milk valve open
// S_CHOCO  | chocolate valve open
// S_AZUCAR | sugar valve open
// S_DONE   | bebida_lista pulse
// S_CAMBIO | change presented with cambio_valid; credit cleared on exit
module maquina_cafe_param #(
    parameter int N_BEBIDAS   = 5,
    parameter int CREDIT_W    = 12,
    parameter int VAL_C       = 100,
    parameter int VAL_Q       = 500,
    parameter int MAX_CREDIT  = 2000,
    parameter int STEP_CYCLES = 4,
    parameter logic [N_BEBIDAS*CREDIT_W-1:0] PRECIOS =
        {12'd500, 12'd400, 12'd400, 12'd350, 12'd300},
    parameter logic [N_BEBIDAS*4-1:0] RECETAS =
        {4'b1011, 4'b1001, 4'b0111, 4'b0101, 4'b0011}
) (
    input logic           clk_50Mhz,
    input logic           rst,
    maquina_cafe_if.slave bus
);
    localparam int IDX_W = (N_BEBIDAS > 1) ? $clog2(N_BEBIDAS) : 1;
    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int SUM_W = CREDIT_W + 2;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AGUA   = 3'd1,
        S_CAFE   = 3'd2,
        S_LECHE  = 3'd3,
        S_CHOCO  = 3'd4,
        S_AZUCAR = 3'd5,
        S_DONE   = 3'd6,
        S_CAMBIO = 3'd7
    } state_t;

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credito, credito_nxt;
    logic [CREDIT_W-1:0] cambio, cambio_nxt;
    logic [CREDIT_W-1:0] precio, precio_nxt;
    logic [4:0]          receta, receta_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                err, err_nxt;
    logic                coin_c_q, coin_q_q, cancel_q;

    logic                rise_c, rise_q, rise_cancel;
    logic [SUM_W-1:0]    coin_sum;
    logic                sel_onehot;
    logic [IDX_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] precio_sel;
    logic [4:0]          receta_sel;

    // Stage states are numbered so that stage index i lives at state value i+1;
    // searching from index n therefore means "after the stage whose value is n".
    function automatic state_t next_stage(input logic [4:0] m, input int from);
        state_t s;
        s = S_DONE;
        for (int i = 4; i >= 0; i--) begin
            if (i >= from && m[i]) s = state_t'(3'(i + 1));
        end
        return s;
    endfunction

    assign rise_c      = bus.coin_c & ~coin_c_q;
    assign rise_q      = bus.coin_q & ~coin_q_q;
    assign rise_cancel = bus.cancel & ~cancel_q;
    assign coin_sum    = SUM_W'(credito)
                       + (rise_c ? SUM_W'(VAL_C) : SUM_W'(0))
                       + (rise_q ? SUM_W'(VAL_Q) : SUM_W'(0));

    assign sel_onehot = (bus.sel != '0) && ((bus.sel & (bus.sel - 1'b1)) == '0);

    // Decode the selected drink index; only meaningful when sel is one-hot.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_BEBIDAS; i++) begin
            if (bus.sel[i]) sel_idx = IDX_W'(i);
        end
    end

    assign precio_sel = PRECIOS[sel_idx*CREDIT_W +: CREDIT_W];
    assign receta_sel = {bus.azucar_req, RECETAS[sel_idx*4 +: 4]};

    // Edge history tracks the panel inputs in every state, so a coin held
    // through a dispense is not counted when the machine returns to idle.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            coin_c_q <= 1'b0;
            coin_q_q <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            coin_c_q <= bus.coin_c;
            coin_q_q <= bus.coin_q;
            cancel_q <= bus.cancel;
        end
    end

    // State register.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Datapath registers: credit, change, latched drink, stage timer, err pulse.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            credito <= '0;
            cambio  <= '0;
            precio  <= '0;
            receta  <= '0;
            timer   <= '0;
            err     <= 1'b0;
        end else begin
            credito <= credito_nxt;
            cambio  <= cambio_nxt;
            precio  <= precio_nxt;
            receta  <= receta_nxt;
            timer   <= timer_nxt;
            err     <= err_nxt;
        end
    end

    // Next-state and datapath update. In idle a selection wins over coins
    // and cancel in the same cycle; outside idle all panel inputs are ignored.
    always_comb begin
        state_nxt   = state;
        credito_nxt = credito;
        cambio_nxt  = cambio;
        precio_nxt  = precio;
        receta_nxt  = receta;
        timer_nxt   = timer;
        err_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.sel != '0) begin
                    if (!sel_onehot || credito < precio_sel) begin
                        err_nxt = 1'b1;
                    end else begin
                        precio_nxt = precio_sel;
                        receta_nxt = receta_sel;
                        timer_nxt  = TMR_LOAD;
                        state_nxt  = next_stage(receta_sel, 0);
                    end
                end else if (rise_c || rise_q) begin
                    if (coin_sum > SUM_W'(MAX_CREDIT)) err_nxt = 1'b1;
                    else credito_nxt = coin_sum[CREDIT_W-1:0];
                end else if (rise_cancel && credito != '0) begin
                    cambio_nxt = credito;
                    state_nxt  = S_CAMBIO;
                end
            end
            S_AGUA, S_CAFE, S_LECHE, S_CHOCO, S_AZUCAR: begin
                if (timer == '0) begin
                    timer_nxt = TMR_LOAD;
                    state_nxt = next_stage(receta, int'(state));
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            S_DONE: begin
                cambio_nxt = credito - precio;
                state_nxt  = S_CAMBIO;
            end
            S_CAMBIO: begin
                credito_nxt = '0;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.agua         = (state == S_AGUA);
    assign bus.cafe         = (state == S_CAFE);
    assign bus.leche        = (state == S_LECHE);
    assign bus.choco        = (state == S_CHOCO);
    assign bus.azucar       = (state == S_AZUCAR);
    assign bus.bebida_lista = (state == S_DONE);
    assign bus.cambio_valid = (state == S_CAMBIO);
    assign bus.busy         = (state != S_IDLE);
    assign bus.cambio       = cambio;
    assign bus.credito      = credito;
    assign bus.err          = err;
endmodule

// File: tb/tb_maquina_cafe_param.sv
// Bench for maquina_cafe_param: directed panel stimulus pushes expected
// output events into a queue; a negedge monitor pops and compares every
// cycle in which the controller shows valve, ready, change or err activity.
module tb_maquina_cafe_param;
    localparam int NB   = 5;
    localparam int CW   = 12;
    localparam int STEP = 4;

    logic clk_50Mhz = 1'b0;
    logic rst       = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    logic [31:0] exp_q[$];

    maquina_cafe_if #(.N_BEBIDAS(NB), .CREDIT_W(CW)) bus ();

    maquina_cafe_param dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .bus       (bus.slave)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    // Event word: {valves[4:0], bebida_lista, cambio_valid, err, cambio, credito}
    function automatic logic [31:0] ev(input logic [4:0] v, input logic l,
                                       input logic cv, input logic e,
                                       input logic [11:0] cb, input logic [11:0] cr);
        return {v, l, cv, e, cb, cr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic exp_drink(input logic [4:0] rec, input logic [11:0] cr, input logic [11:0] cb);
        for (int i = 0; i < 5; i++)
            if (rec[i]) repeat (STEP) exp_q.push_back(ev(5'(1 << i), 1'b0, 1'b0, 1'b0, 12'd0, cr));
        exp_q.push_back(ev(5'd0, 1'b1, 1'b0, 1'b0, 12'd0, cr));
        exp_q.push_back(ev(5'd0, 1'b0, 1'b1, 1'b0, cb, cr));
    endtask

    task automatic coin_c_pulse();
        bus.coin_c = 1'b1; tick(); bus.coin_c = 1'b0; tick();
    endtask

    task automatic coin_q_pulse();
        bus.coin_q = 1'b1; tick(); bus.coin_q = 1'b0; tick();
    endtask

    task automatic select(input logic [4:0] s, input logic az);
        bus.sel = s; bus.azucar_req = az; tick();
        bus.sel = '0; bus.azucar_req = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    // Monitor: any active output cycle must match the head of the queue.
    initial begin
        logic [31:0] obs;
        forever begin
            @(negedge clk_50Mhz);
            if (rst && (bus.agua || bus.cafe || bus.leche || bus.choco || bus.azucar ||
                        bus.bebida_lista || bus.cambio_valid || bus.err)) begin
                obs = ev({bus.azucar, bus.choco, bus.leche, bus.cafe, bus.agua},
                         bus.bebida_lista, bus.cambio_valid, bus.err,
                         bus.cambio_valid ? bus.cambio : 12'd0, bus.credito);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got 0x%08h expected no activity", obs);
                end else begin
                    check("scoreboard_event", obs, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        bus.sel = '0; bus.azucar_req = 1'b0;
        bus.coin_c = 1'b0; bus.coin_q = 1'b0; bus.cancel = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_flags", 32'({bus.agua, bus.cafe, bus.leche, bus.choco, bus.azucar,
              bus.bebida_lista, bus.cambio_valid, bus.err, bus.busy}), 32'd0);
        check("reset_credito", 32'(bus.credito), 32'd0);
        check("reset_cambio", 32'(bus.cambio), 32'd0);
        rst = 1'b1;
        tick();

        // 1: held coins count once each
        bus.coin_c = 1'b1; repeat (3) tick(); bus.coin_c = 1'b0; tick();
        check("credit_100", 32'(bus.credito), 32'd100);
        bus.coin_q = 1'b1; repeat (2) tick(); bus.coin_q = 1'b0; tick();
        check("credit_600", 32'(bus.credito), 32'd600);
        bus.coin_c = 1'b1; repeat (2) tick(); bus.coin_c = 1'b0; tick();
        check("credit_700", 32'(bus.credito), 32'd700);

        // 2: drink 0 (agua+cafe, 300) with 700 credit
        exp_drink(5'b00011, 12'd700, 12'd400);
        select(5'b00001, 1'b0);
        wait_idle(n);
        check("drink0_busy_cycles", 32'(n), 32'(2*STEP + 2));
        check("drink0_credit_cleared", 32'(bus.credito), 32'd0);
        check("drink0_queue_drained", 32'(exp_q.size()), 32'd0);

        // 3: insufficient credit for drink 2
        coin_c_pulse(); coin_c_pulse(); coin_c_pulse();
        check("credit_300", 32'(bus.credito), 32'd300);
        exp_q.push_back(ev(5'd0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd300));
        select(5'b00100, 1'b1);
        check("lowcredit_not_busy", 32'(bus.busy), 32'd0);
        tick();
        check("lowcredit_keeps_300", 32'(bus.credito), 32'd300);

        // 4: ceiling overflow and non-one-hot selection
        coin_q_pulse(); coin_q_pulse(); coin_c_pulse(); coin_c_pulse(); coin_c_pulse();
        check("credit_1600", 32'(bus.credito), 32'd1600);
        exp_q.push_back(ev(5'd0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd1600));
        coin_q_pulse();
        check("overflow_keeps_1600", 32'(bus.credito), 32'd1600);
        exp_q.push_back(ev(5'd0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd1600));
        select(5'b00011, 1'b0);
        tick();
        check("multisel_keeps_1600", 32'(bus.credito), 32'd1600);

        // 5: cancel returns credit; held coin during dispense ignored
        exp_q.push_back(ev(5'd0, 1'b0, 1'b1, 1'b0, 12'd1600, 12'd1600));
        bus.cancel = 1'b1; tick(); bus.cancel = 1'b0; tick();
        check("cancel1600_credit0", 32'(bus.credito), 32'd0);
        coin_q_pulse(); coin_c_pulse();
        check("credit_600b", 32'(bus.credito), 32'd600);
        exp_q.push_back(ev(5'd0, 1'b0, 1'b1, 1'b0, 12'd600, 12'd600));
        bus.cancel = 1'b1; tick(); bus.cancel = 1'b0; tick();
        check("cancel600_credit0", 32'(bus.credito), 32'd0);
        bus.cancel = 1'b1; tick(); bus.cancel = 1'b0; tick();
        check("cancel_zero_noop", 32'(bus.busy), 32'd0);
        coin_q_pulse(); coin_c_pulse();
        exp_drink(5'b00101, 12'd600, 12'd250);
        select(5'b00010, 1'b0);
        bus.coin_c = 1'b1;
        wait_idle(n);
        check("drink1_busy_cycles", 32'(n), 32'(2*STEP + 2));
        repeat (2) tick();
        check("held_coin_not_counted", 32'(bus.credito), 32'd0);
        bus.coin_c = 1'b0;
        tick();

        // 6: reset in the middle of the chocolate stage
        coin_q_pulse();
        check("credit_500", 32'(bus.credito), 32'd500);
        repeat (STEP) exp_q.push_back(ev(5'b00001, 1'b0, 1'b0, 1'b0, 12'd0, 12'd500));
        repeat (2)    exp_q.push_back(ev(5'b01000, 1'b0, 1'b0, 1'b0, 12'd0, 12'd500));
        select(5'b01000, 1'b0);
        repeat (STEP + 1) tick();
        @(negedge clk_50Mhz);
        #1 rst = 1'b0;
        #1;
        check("midreset_flags", 32'({bus.agua, bus.cafe, bus.leche, bus.choco, bus.azucar,
              bus.bebida_lista, bus.cambio_valid, bus.err, bus.busy}), 32'd0);
        check("midreset_credito", 32'(bus.credito), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("after_reset_idle", 32'({bus.busy, bus.credito}), 32'd0);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
